// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: writeback stage has priority, mul/div
// results queue in a FIFO and drain into idle slots; stall_req on starvation.
// Ports: clk, rst_n; wb_we/wb_addr/wb_data from writeback; mc_valid/mc_addr/
// mc_data/mc_ready from the multi-cycle unit; rf_we/rf_addr/rf_data to the
// register file (registered); stall_req (registered); pend_cnt occupancy.
// Optional macro WB_ARB_R0_DISCARD_EN drops every write to r0.
module wb_port_arbiter #(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 4,
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wb_we,
  input  logic [ADDR_W-1:0]        wb_addr,
  input  logic [DATA_W-1:0]        wb_data,
  input  logic                     mc_valid,
  input  logic [ADDR_W-1:0]        mc_addr,
  input  logic [DATA_W-1:0]        mc_data,
  output logic                     mc_ready,
  output logic                     rf_we,
  output logic [ADDR_W-1:0]        rf_addr,
  output logic [DATA_W-1:0]        rf_data,
  output logic                     stall_req,
  output logic [$clog2(DEPTH):0]   pend_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int AW = $clog2(STARVE_MAX + 1);
  localparam int EW = ADDR_W + DATA_W;

  logic [EW-1:0]     mem_q [DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [AW-1:0]     age_q, age_d;
  logic              rf_we_q, rf_we_d;
  logic [ADDR_W-1:0] rf_addr_q, rf_addr_d;
  logic [DATA_W-1:0] rf_data_q, rf_data_d;
  logic              stall_q, stall_d;

  logic              empty;
  logic              mc_acc;
  logic              wb_go;
  logic              mc_go;
  logic              pop;
  logic              byp;
  logic              push;
  logic [EW-1:0]     head;

  always_comb begin
    empty    = (cnt_q == '0);
    mc_ready = (cnt_q < CW'(DEPTH));
    mc_acc   = mc_valid && mc_ready;
`ifdef WB_ARB_R0_DISCARD_EN
    // r0 writes are swallowed; an r0 wb slot is free for a FIFO pop
    wb_go = wb_we && (wb_addr != '0);
    mc_go = mc_acc && (mc_addr != '0);
`else
    wb_go = wb_we;
    mc_go = mc_acc;
`endif
    head = mem_q[rd_ptr_q];
    pop  = !wb_go && !empty;
    byp  = !wb_go && empty && mc_go;
    push = mc_go && !byp;

    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;

    cnt_d = cnt_q;
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase

    age_d = age_q;
    if (empty || pop)
      age_d = '0;
    else if (age_q < AW'(STARVE_MAX))
      age_d = age_q + 1'b1;
    stall_d = (age_d == AW'(STARVE_MAX));

    rf_we_d   = 1'b0;
    rf_addr_d = rf_addr_q;
    rf_data_d = rf_data_q;
    unique case (1'b1)
      wb_go: begin
        rf_we_d   = 1'b1;
        rf_addr_d = wb_addr;
        rf_data_d = wb_data;
      end
      pop: begin
        rf_we_d   = 1'b1;
        rf_addr_d = head[EW-1:DATA_W];
        rf_data_d = head[DATA_W-1:0];
      end
      byp: begin
        rf_we_d   = 1'b1;
        rf_addr_d = mc_addr;
        rf_data_d = mc_data;
      end
      default: ;
    endcase
  end

  // storage needs no reset: occupancy is tracked by the pointers/count
  always_ff @(posedge clk) begin
    if (push)
      mem_q[wr_ptr_q] <= {mc_addr, mc_data};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      age_q     <= '0;
      rf_we_q   <= 1'b0;
      rf_addr_q <= '0;
      rf_data_q <= '0;
      stall_q   <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      age_q     <= age_d;
      rf_we_q   <= rf_we_d;
      rf_addr_q <= rf_addr_d;
      rf_data_q <= rf_data_d;
      stall_q   <= stall_d;
    end
  end

  assign rf_we     = rf_we_q;
  assign rf_addr   = rf_addr_q;
  assign rf_data   = rf_data_q;
  assign stall_req = stall_q;
  assign pend_cnt  = cnt_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: reference model feeds an expected-write
// queue each cycle; DUT register-file writes are popped and compared.
module tb_wb_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wb_we;
  logic [3:0]  wb_addr;
  logic [15:0] wb_data;
  logic        mc_valid;
  logic [3:0]  mc_addr;
  logic [15:0] mc_data;
  logic        mc_ready;
  logic        rf_we;
  logic [3:0]  rf_addr;
  logic [15:0] rf_data;
  logic        stall_req;
  logic [2:0]  pend_cnt;

  always #5 clk = ~clk;

  wb_port_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wb_we     (wb_we),
    .wb_addr   (wb_addr),
    .wb_data   (wb_data),
    .mc_valid  (mc_valid),
    .mc_addr   (mc_addr),
    .mc_data   (mc_data),
    .mc_ready  (mc_ready),
    .rf_we     (rf_we),
    .rf_addr   (rf_addr),
    .rf_data   (rf_data),
    .stall_req (stall_req),
    .pend_cnt  (pend_cnt)
  );

  typedef struct {
    logic        we;
    logic [3:0]  a;
    logic [15:0] d;
  } wr_t;

  wr_t         exp_q[$];
  logic [19:0] mq[$];
  int          age_m;
  logic        stall_m;
  int          checks;
  int          failures;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input logic we, input logic [3:0] wa,
                      input logic [15:0] wd, input logic mv,
                      input logic [3:0] ma, input logic [15:0] md);
    wr_t  e;
    logic acc, wgo, mgo, pop, byp;
    int   sz;
    @(negedge clk);
    wb_we    = we;
    wb_addr  = wa;
    wb_data  = wd;
    mc_valid = mv;
    mc_addr  = ma;
    mc_data  = md;
    sz = mq.size();
    check("mc_ready", {31'd0, mc_ready}, {31'd0, sz < 4});
    check("pend_cnt", {29'd0, pend_cnt}, sz);
    check("stall_req", {31'd0, stall_req}, {31'd0, stall_m});
    acc = mv && (sz < 4);
    wgo = we;
    mgo = acc;
`ifdef WB_ARB_R0_DISCARD_EN
    wgo = we && (wa != 4'd0);
    mgo = acc && (ma != 4'd0);
`endif
    e.we = 1'b0;
    e.a  = '0;
    e.d  = '0;
    pop = !wgo && (sz > 0);
    byp = !wgo && (sz == 0) && mgo;
    if (wgo) begin
      e.we = 1'b1; e.a = wa; e.d = wd;
    end else if (pop) begin
      e.we = 1'b1;
      {e.a, e.d} = mq.pop_front();
    end else if (byp) begin
      e.we = 1'b1; e.a = ma; e.d = md;
    end
    if (mgo && !byp)
      mq.push_back({ma, md});
    if (sz == 0 || pop)
      age_m = 0;
    else if (age_m < 8)
      age_m++;
    stall_m = (age_m == 8);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check("rf_we", {31'd0, rf_we}, {31'd0, e.we});
    if (e.we) begin
      check("rf_addr", {28'd0, rf_addr}, {28'd0, e.a});
      check("rf_data", {16'd0, rf_data}, {16'd0, e.d});
    end
  endtask

  task automatic idle();
    step(1'b0, 4'd0, 16'd0, 1'b0, 4'd0, 16'd0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    age_m    = 0;
    stall_m  = 1'b0;
    rst_n    = 1'b0;
    wb_we    = 1'b0;
    wb_addr  = '0;
    wb_data  = '0;
    mc_valid = 1'b0;
    mc_addr  = '0;
    mc_data  = '0;
    #12;
    check("rst_rf_we", {31'd0, rf_we}, 0);
    check("rst_pend", {29'd0, pend_cnt}, 0);
    check("rst_stall", {31'd0, stall_req}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // bypass into empty FIFO
    step(1'b0, 4'd0, 16'd0, 1'b1, 4'd5, 16'h1234);
    check("byp_pend", {29'd0, pend_cnt}, 0);
    idle();

    // wb priority, mc queued then drained on idle slot
    step(1'b1, 4'd2, 16'hAAAA, 1'b1, 4'd7, 16'h0BEE);
    check("prio_pend", {29'd0, pend_cnt}, 1);
    idle();
    check("prio_drain", {29'd0, pend_cnt}, 0);

    // fill to DEPTH while wb busy, 5th refused, then drain in order
    for (int i = 0; i < 5; i++)
      step(1'b1, 4'd1, 16'h1000 + 16'(i), 1'b1,
           4'(8 + i), 16'hC000 + 16'(i));
    check("full_ready", {31'd0, mc_ready}, 0);
    check("full_pend", {29'd0, pend_cnt}, 4);
    for (int i = 0; i < 4; i++)
      idle();
    check("drain_pend", {29'd0, pend_cnt}, 0);

    // starvation: one entry held back by continuous wb writes
    step(1'b1, 4'd3, 16'h3333, 1'b1, 4'd9, 16'h9999);
    for (int i = 0; i < 7; i++)
      step(1'b1, 4'd4, 16'(i), 1'b0, 4'd0, 16'd0);
    check("stall_7", {31'd0, stall_req}, 0);
    step(1'b1, 4'd4, 16'h0044, 1'b0, 4'd0, 16'd0);
    check("stall_8", {31'd0, stall_req}, 1);
    idle();
    check("stall_drop", {31'd0, stall_req}, 0);
    idle();

`ifdef WB_ARB_R0_DISCARD_EN
    step(1'b0, 4'd0, 16'd0, 1'b1, 4'd0, 16'hFFFF);
    check("r0_mc_we", {31'd0, rf_we}, 0);
    check("r0_mc_pend", {29'd0, pend_cnt}, 0);
    step(1'b1, 4'd3, 16'h0303, 1'b1, 4'd6, 16'h0606);
    step(1'b1, 4'd0, 16'hDEAD, 1'b0, 4'd0, 16'd0);
    check("r0_wb_pop", {29'd0, pend_cnt}, 0);
    idle();
`endif

    // reset mid-stream with three entries pending
    for (int i = 0; i < 3; i++)
      step(1'b1, 4'd2, 16'h2000 + 16'(i), 1'b1,
           4'(10 + i), 16'hE000 + 16'(i));
    check("pre_rst_pend", {29'd0, pend_cnt}, 3);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_we", {31'd0, rf_we}, 0);
    check("mid_rst_addr", {28'd0, rf_addr}, 0);
    check("mid_rst_data", {16'd0, rf_data}, 0);
    check("mid_rst_stall", {31'd0, stall_req}, 0);
    check("mid_rst_pend", {29'd0, pend_cnt}, 0);
    mq.delete();
    exp_q.delete();
    age_m   = 0;
    stall_m = 1'b0;
    wb_we    = 1'b0;
    mc_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++)
      idle();

    // random traffic, upstream honours stall_req
    for (int i = 0; i < 300; i++) begin
      logic we;
      we = stall_req ? 1'b0 : 1'($urandom_range(0, 99) < 60);
      step(we, 4'($urandom), 16'($urandom),
           1'($urandom_range(0, 99) < 50),
           4'($urandom), 16'($urandom));
    end
    for (int i = 0; i < 6; i++)
      idle();
    check("end_pend", {29'd0, pend_cnt}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
